// File: rtl/hid_pkg.sv
// Shared definitions for the HID boot-keyboard report path: key codes,
// report geometry and the assembler state encoding.
package hid_pkg;

  localparam int NUM_KEYS             = 4;
  localparam int REPORT_BYTES         = 8;
  localparam int DEFAULT_STALE_FRAMES = 30;

  localparam logic [7:0] KEY_NONE     = 8'h00;
  localparam logic [7:0] KEY_ROLLOVER = 8'h01;
  localparam logic [7:0] KEY_A        = 8'h04;
  localparam logic [7:0] KEY_D        = 8'h07;
  localparam logic [7:0] KEY_S        = 8'h16;
  localparam logic [7:0] KEY_W        = 8'h1A;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHECK
  } asm_state_t;

endpackage

// File: rtl/hid_stale_timer.sv
// Counts frame ticks that pass without a committed report. The count
// saturates at STALE_FRAMES; expired pulses on the tick that brings the
// count up to STALE_FRAMES so the owner can clear its held keys once.
module hid_stale_timer #(
  parameter int STALE_FRAMES = 30
) (
  input  logic Clk,
  input  logic Reset,
  input  logic tick,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(STALE_FRAMES + 1);
  localparam logic [CW-1:0] LIMIT     = CW'(STALE_FRAMES);
  localparam logic [CW-1:0] LAST_STEP = CW'(STALE_FRAMES - 1);

  logic [CW-1:0] count;

  // Saturating tick counter; a commit restarts the timeout window.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = tick && !clear && (count == LAST_STEP);

endmodule

// File: rtl/hid_report_assembler.sv
// Assembles 8-byte boot-keyboard reports from a byte stream, compacts the
// first four non-zero key slots, and hands the result to the fighter
// controllers only on frame_tick so a frame never sees a torn report.
module hid_report_assembler
  import hid_pkg::*;
#(
  parameter int STALE_FRAMES = DEFAULT_STALE_FRAMES
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       byte_sop,
  output logic       byte_ready,
  input  logic       frame_tick,
  output logic [7:0] keycode_0,
  output logic [7:0] keycode_1,
  output logic [7:0] keycode_2,
  output logic [7:0] keycode_3,
  output logic [7:0] modifier,
  output logic [7:0] report_count,
  output logic       err_rollover,
  output logic       stale
);

  localparam logic [2:0] SLOT_LIMIT     = 3'(NUM_KEYS);
  localparam logic [2:0] FIRST_KEY_BYTE = 3'd2;
  localparam logic [2:0] LAST_BYTE      = 3'(REPORT_BYTES - 1);

  asm_state_t state;
  logic [2:0] byte_index;
  logic [7:0] stage_keys [NUM_KEYS];
  logic [2:0] stage_count;
  logic [7:0] stage_mod;
  logic       stage_rollover;

  logic [7:0] pend_keys [NUM_KEYS];
  logic [7:0] pend_mod;
  logic       pend_valid;

  logic xfer;
  logic start_report;
  logic commit;
  logic stale_expired;

  assign xfer         = byte_valid && byte_ready;
  assign start_report = xfer && byte_sop;
  assign commit       = frame_tick && pend_valid;

  hid_stale_timer #(
    .STALE_FRAMES(STALE_FRAMES)
  ) u_stale_timer (
    .Clk    (Clk),
    .Reset  (Reset),
    .tick   (frame_tick),
    .clear  (commit),
    .expired(stale_expired)
  );

  // Byte collection FSM: stages one report, validates it in CHECK and
  // moves it to the pending buffer. A commit empties pending in the same
  // edge that a CHECK may refill it, so the newer report survives.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= IDLE;
      byte_index     <= 3'd0;
      stage_count    <= 3'd0;
      stage_mod      <= KEY_NONE;
      stage_rollover <= 1'b0;
      pend_mod       <= KEY_NONE;
      pend_valid     <= 1'b0;
      byte_ready     <= 1'b1;
      err_rollover   <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        stage_keys[i] <= KEY_NONE;
        pend_keys[i]  <= KEY_NONE;
      end
    end else begin
      err_rollover <= 1'b0;
      if (commit) begin
        pend_valid <= 1'b0;
      end
      if (start_report) begin
        state          <= COLLECT;
        stage_mod      <= byte_data;
        byte_index     <= 3'd1;
        stage_count    <= 3'd0;
        stage_rollover <= 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
          stage_keys[i] <= KEY_NONE;
        end
      end else begin
        case (state)
          IDLE: begin
          end
          COLLECT: begin
            if (xfer) begin
              byte_index <= byte_index + 3'd1;
              if (byte_index >= FIRST_KEY_BYTE) begin
                if (byte_data == KEY_ROLLOVER) begin
                  stage_rollover <= 1'b1;
                end
                if ((byte_data != KEY_NONE) && (stage_count < SLOT_LIMIT)) begin
                  stage_keys[stage_count[1:0]] <= byte_data;
                  stage_count                  <= stage_count + 3'd1;
                end
              end
              if (byte_index == LAST_BYTE) begin
                state      <= CHECK;
                byte_ready <= 1'b0;
              end
            end
          end
          CHECK: begin
            if (stage_rollover) begin
              err_rollover <= 1'b1;
            end else begin
              pend_keys  <= stage_keys;
              pend_mod   <= stage_mod;
              pend_valid <= 1'b1;
            end
            state      <= IDLE;
            byte_index <= 3'd0;
            byte_ready <= 1'b1;
          end
          default: begin
            state      <= IDLE;
            byte_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  // Consumer-facing registers: change only on a tick that commits pending
  // or on the tick that times the held keys out.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      keycode_0    <= KEY_NONE;
      keycode_1    <= KEY_NONE;
      keycode_2    <= KEY_NONE;
      keycode_3    <= KEY_NONE;
      modifier     <= KEY_NONE;
      report_count <= 8'd0;
      stale        <= 1'b0;
    end else if (commit) begin
      keycode_0    <= pend_keys[0];
      keycode_1    <= pend_keys[1];
      keycode_2    <= pend_keys[2];
      keycode_3    <= pend_keys[3];
      modifier     <= pend_mod;
      report_count <= report_count + 8'd1;
      stale        <= 1'b0;
    end else if (stale_expired) begin
      keycode_0 <= KEY_NONE;
      keycode_1 <= KEY_NONE;
      keycode_2 <= KEY_NONE;
      keycode_3 <= KEY_NONE;
      modifier  <= KEY_NONE;
      stale     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hid_report_assembler.sv
// Bench for hid_report_assembler: directed reports plus random byte
// streams, checked against a report-level model through a scoreboard.
module tb_hid_report_assembler;

  localparam int STALE = 30;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] byte_data = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_sop = 1'b0;
  logic       byte_ready;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode_0, keycode_1, keycode_2, keycode_3;
  logic [7:0] modifier, report_count;
  logic       err_rollover, stale;

  typedef struct packed {
    logic [7:0] k0, k1, k2, k3, mod, cnt;
    logic       stl;
  } exp_t;

  exp_t expQ[$];
  int   rollQ[$];
  int   nChecks = 0;
  int   nFails = 0;

  logic [7:0] mPend [4];
  logic [7:0] mPendMod;
  bit         mPendValid;
  exp_t       mOut;
  int         mStaleCnt;

  always #5 Clk = ~Clk;

  hid_report_assembler #(.STALE_FRAMES(STALE)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_sop    (byte_sop),
    .byte_ready  (byte_ready),
    .frame_tick  (frame_tick),
    .keycode_0   (keycode_0),
    .keycode_1   (keycode_1),
    .keycode_2   (keycode_2),
    .keycode_3   (keycode_3),
    .modifier    (modifier),
    .report_count(report_count),
    .err_rollover(err_rollover),
    .stale       (stale)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Report-level reference model
  task automatic modelReset();
    mPendValid = 0;
    mPendMod   = 8'h00;
    for (int s = 0; s < 4; s++) mPend[s] = 8'h00;
    mOut      = '0;
    mStaleCnt = 0;
  endtask

  task automatic modelReport(input logic [63:0] rpt);
    logic [7:0] keys[$];
    bit roll = 0;
    for (int i = 2; i < 8; i++) begin
      logic [7:0] b = rpt[8*i +: 8];
      if (b == 8'h01) roll = 1;
      if (b != 8'h00) keys.push_back(b);
    end
    if (roll) begin
      rollQ.push_back(1);
    end else begin
      for (int s = 0; s < 4; s++) mPend[s] = (s < keys.size()) ? keys[s] : 8'h00;
      mPendMod   = rpt[7:0];
      mPendValid = 1;
    end
  endtask

  task automatic modelTick();
    if (mPendValid) begin
      mOut.k0    = mPend[0];
      mOut.k1    = mPend[1];
      mOut.k2    = mPend[2];
      mOut.k3    = mPend[3];
      mOut.mod   = mPendMod;
      mOut.cnt   = mOut.cnt + 8'd1;
      mOut.stl   = 1'b0;
      mStaleCnt  = 0;
      mPendValid = 0;
    end else if (mStaleCnt < STALE) begin
      mStaleCnt++;
      if (mStaleCnt == STALE) begin
        mOut.k0  = 8'h00;
        mOut.k1  = 8'h00;
        mOut.k2  = 8'h00;
        mOut.k3  = 8'h00;
        mOut.mod = 8'h00;
        mOut.stl = 1'b1;
      end
    end
    expQ.push_back(mOut);
  endtask

  // Drivers: all inputs change on the falling edge
  task automatic sendByte(input logic [7:0] d, input logic sop);
    int w = 0;
    while (!byte_ready && w < 20) begin
      @(negedge Clk);
      w++;
    end
    if (w >= 20) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL byte_ready_timeout: got ready=0 for 20 cycles, expected 1");
    end
    byte_data  = d;
    byte_sop   = sop;
    byte_valid = 1'b1;
    @(negedge Clk);
    byte_valid = 1'b0;
    byte_sop   = 1'b0;
  endtask

  task automatic tickPulse();
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  task automatic tickOnly();
    modelTick();
    tickPulse();
  endtask

  // Sends nBytes of a report; tickDelay 1 lands the tick on the CHECK
  // cycle, 2+ lands it after pending is loaded, 0 sends no tick.
  task automatic applyStimulus(input logic [63:0] rpt, input int nBytes, input int tickDelay);
    for (int i = 0; i < nBytes; i++) sendByte(rpt[8*i +: 8], (i == 0));
    if (nBytes < 8) return;
    if (tickDelay == 1) begin
      modelTick();
      tickPulse();
      modelReport(rpt);
    end else begin
      modelReport(rpt);
      @(negedge Clk);
      if (tickDelay >= 2) begin
        repeat (tickDelay - 2) @(negedge Clk);
        modelTick();
        tickPulse();
      end
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] mod, input logic [7:0] k2, input logic [7:0] k3,
                                     input logic [7:0] k4, input logic [7:0] k5, input logic [7:0] k6,
                                     input logic [7:0] k7);
    return {k7, k6, k5, k4, k3, k2, 8'h00, mod};
  endfunction

  function automatic logic [7:0] randKey();
    int r = $urandom_range(0, 39);
    logic [7:0] v;
    if (r < 15) v = 8'h00;
    else if (r == 15) v = 8'h01;
    else if (r < 20) v = (r < 18) ? 8'h04 : 8'h07;
    else if (r < 24) v = (r < 22) ? 8'h16 : 8'h1A;
    else v = 8'($urandom_range(2, 255));
    return v;
  endfunction

  function automatic logic [63:0] randReport();
    logic [63:0] r;
    r[7:0]  = 8'($urandom);
    r[15:8] = 8'($urandom);
    for (int i = 2; i < 8; i++) r[8*i +: 8] = randKey();
    return r;
  endfunction

  // Monitor: pops an expectation on every tick, otherwise checks hold
  initial begin
    exp_t cur = '0;
    exp_t act;
    logic t, r;
    forever begin
      @(posedge Clk);
      t = frame_tick;
      r = Reset;
      @(negedge Clk);
      if (r) begin
        cur = '0;
        checkOutput("ready_in_reset", byte_ready, 1'b1);
      end else if (t) begin
        checkOutput("tick_expected", expQ.size() != 0, 1'b1);
        if (expQ.size() != 0) cur = expQ.pop_front();
      end
      act = {keycode_0, keycode_1, keycode_2, keycode_3, modifier, report_count, stale};
      checkOutput(t ? "tick_outputs" : "hold_outputs", act, cur);
      if (err_rollover) begin
        checkOutput("rollover_expected", rollQ.size() != 0, 1'b1);
        if (rollQ.size() != 0) void'(rollQ.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("byte_ready_after_reset", byte_ready, 1'b1);
    checkOutput("count_after_reset", report_count, 8'd0);

    applyStimulus(mk(8'h00, 8'h04, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00), 8, 2);
    checkOutput("basic_k0", keycode_0, 8'h04);
    checkOutput("basic_k1", keycode_1, 8'h1A);
    checkOutput("basic_k2", keycode_2, 8'h00);
    checkOutput("basic_count", report_count, 8'd1);

    applyStimulus(mk(8'h02, 8'h07, 8'h16, 8'h04, 8'h1A, 8'h2C, 8'h00), 8, 3);
    checkOutput("fifth_key_dropped", {keycode_0, keycode_1, keycode_2, keycode_3}, 32'h0716041A);
    checkOutput("modifier_taken", modifier, 8'h02);

    applyStimulus(mk(8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01), 8, 2);
    checkOutput("rollover_keeps_k0", keycode_0, 8'h07);

    applyStimulus(mk(8'h05, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00), 4, 0);
    applyStimulus(mk(8'h00, 8'h16, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, 2);
    checkOutput("abort_new_k0", keycode_0, 8'h16);
    checkOutput("abort_new_k1", keycode_1, 8'h00);

    applyStimulus(mk(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, 0);
    applyStimulus(mk(8'h00, 8'h1A, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00), 8, 2);
    checkOutput("latest_wins_count", report_count, 8'd4);

    applyStimulus(mk(8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, 0);
    applyStimulus(mk(8'h02, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, 1);
    checkOutput("coincident_old_commit", keycode_0, 8'h04);
    tickOnly();

    applyStimulus(mk(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, 2);
    for (int i = 0; i < STALE - 1; i++) begin
      tickOnly();
      @(negedge Clk);
    end
    checkOutput("not_yet_stale", {stale, keycode_0}, {1'b0, 8'h04});
    tickOnly();
    checkOutput("stale_cleared", {stale, keycode_0}, {1'b1, 8'h00});
    applyStimulus(mk(8'h00, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, 2);
    checkOutput("stale_recovered", {stale, keycode_0}, {1'b0, 8'h1A});

    applyStimulus(mk(8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, 0);
    applyStimulus(mk(8'h00, 8'h16, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 5, 0);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    modelReset();
    tickOnly();
    checkOutput("reset_drops_pending", report_count, 8'd0);

    for (int it = 0; it < 150; it++) begin
      int a = $urandom_range(0, 9);
      if (a <= 5) begin
        applyStimulus(randReport(), 8, $urandom_range(0, 3));
      end else if (a == 6) begin
        applyStimulus(randReport(), $urandom_range(1, 7), 0);
        applyStimulus(randReport(), 8, $urandom_range(0, 3));
      end else if (a == 7) begin
        sendByte(8'($urandom), 1'b0);
      end else begin
        tickOnly();
        repeat ($urandom_range(0, 2)) @(negedge Clk);
      end
    end

    repeat (10) @(negedge Clk);
    checkOutput("ticks_drained", expQ.size(), 0);
    checkOutput("rollover_pulses_drained", rollQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
